// File: rtl/aes_pkg.sv
// AES GF(2^8) helpers shared by the inverse-cipher datapath stages.
package aes_pkg;

    // Low byte of the AES field polynomial x^8+x^4+x^3+x+1
    localparam logic [7:0] RED_POLY = 8'h1b;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    // Multiply by x (0x02) with reduction when bit 7 is shifted out
    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? RED_POLY : 8'h00);
    endfunction

    // 0x09 = x^3 + 1
    function automatic byte_t gmul09(input byte_t a);
        byte_t x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ a;
    endfunction

    // 0x0b = x^3 + x + 1
    function automatic byte_t gmul0b(input byte_t a);
        byte_t x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ a;
    endfunction

    // 0x0d = x^3 + x^2 + 1
    function automatic byte_t gmul0d(input byte_t a);
        byte_t x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    // 0x0e = x^3 + x^2 + x
    function automatic byte_t gmul0e(input byte_t a);
        byte_t x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns of one 32-bit state column (row 0 in the MSB byte).
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] res
);

    byte_t a0, a1, a2, a3;
    byte_t b0, b1, b2, b3;

    assign a0 = col[31:24];
    assign a1 = col[23:16];
    assign a2 = col[15:8];
    assign a3 = col[7:0];

    // Each output byte is one row of the circulant matrix {0e,0b,0d,09}
    assign b0 = gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3);
    assign b1 = gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3);
    assign b2 = gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3);
    assign b3 = gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3);

    assign res = {b0, b1, b2, b3};

endmodule

// File: rtl/mix_col_dec.sv
// Registered AES-128 InvMixColumns: four parallel column transforms feeding
// a single 128-bit output register with one cycle of latency.
module mix_col_dec
    import aes_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic [127:0] In,
    output logic [127:0] Out
);

    logic [127:0] mix_p0;

    // Column c occupies In[127-32c -: 32]; columns are independent
    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_mix_column u_col (
            .col (In[127-32*c -: 32]),
            .res (mix_p0[127-32*c -: 32])
        );
    end

    // Output register: loads every edge, cleared asynchronously by reset
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Out <= '0;
        end else begin
            Out <= mix_p0;
        end
    end

endmodule

// File: tb/tb_mix_col_dec.sv
// Bench for mix_col_dec: the reference applies forward MixColumns (generic
// GF(2^8) multiply) to Out and expects the In captured one edge earlier.
module tb_mix_col_dec;

    logic         Clk;
    logic         Rst_n;
    logic [127:0] In;
    logic [127:0] Out;

    int checks;
    int failures;

    logic [127:0] exp_in;
    bit           have_prev;

    mix_col_dec dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .In    (In),
        .Out   (Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Shift-and-add multiply in GF(2^8) modulo 0x11B
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    // Forward MixColumns over the whole state
    function automatic logic [127:0] mixcols(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a [4];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
            r[127-32*c    -: 8] = gm(a[0],8'h02) ^ gm(a[1],8'h03) ^ a[2] ^ a[3];
            r[127-32*c-8  -: 8] = a[0] ^ gm(a[1],8'h02) ^ gm(a[2],8'h03) ^ a[3];
            r[127-32*c-16 -: 8] = a[0] ^ a[1] ^ gm(a[2],8'h02) ^ gm(a[3],8'h03);
            r[127-32*c-24 -: 8] = gm(a[0],8'h03) ^ a[1] ^ a[2] ^ gm(a[3],8'h02);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%032h required=%032h at %0t", name, act, req, $time);
        end
    endtask

    // Track the value the DUT should have captured at the last rising edge
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            have_prev = 1'b0;
        end else begin
            exp_in    = In;
            have_prev = 1'b1;
        end
    end

    // Every falling edge: Out must be 0 under reset, else invert back to In
    always @(negedge Clk) begin
        if (!Rst_n) begin
            check("reset_out", Out, 128'h0);
        end else if (have_prev) begin
            check("roundtrip", mixcols(Out), exp_in);
        end
    end

    localparam logic [127:0] V1_IN  = 128'h5f72641557f5bc92f7be3b291db9f91a;
    localparam logic [127:0] V1_OUT = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] V2_IN  = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [127:0] V2_OUT = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] V3_IN  = 128'hd5d5d7d64d7ebdf800000000ffffffff;
    localparam logic [127:0] V3_OUT = 128'hd4d4d4d52d26314c00000000ffffffff;

    initial begin
        checks    = 0;
        failures  = 0;
        have_prev = 1'b0;
        exp_in    = '0;
        Rst_n     = 1'b0;
        In        = V1_IN;

        // Pin the reference model with known forward MixColumns results
        check("model_v1", mixcols(V1_OUT), V1_IN);
        check("model_v2", mixcols(V2_OUT), V2_IN);
        check("model_v3", mixcols(V3_OUT), V3_IN);

        // Hold reset across several edges with a live input
        repeat (4) @(posedge Clk);
        #1 check("reset_hold", Out, 128'h0);

        // Release between edges; first edge loads the transform
        #1 Rst_n = 1'b1;
        @(posedge Clk);
        #1 check("fips_v1", Out, V1_OUT);

        // Back-to-back vectors, each visible one edge after it is presented
        #1 In = V2_IN;
        @(posedge Clk);
        #2 In = V3_IN;
        #1 check("b2b_v2", Out, V2_OUT);
        @(posedge Clk);
        #1 check("b2b_v3", Out, V3_OUT);

        // Change In mid-cycle: Out must hold until the next edge
        #5 In = 128'hffffffffffffffffffffffffffffffff;
        #1 check("midcycle_hold", Out, V3_OUT);
        @(posedge Clk);
        #1 check("all_ones", Out, 128'hffffffffffffffffffffffffffffffff);

        // All-zero input
        #1 In = '0;
        @(posedge Clk);
        #1 check("all_zero", Out, 128'h0);

        // Asynchronous reset between edges after a nonzero Out
        #1 In = V1_IN;
        @(posedge Clk);
        #1 check("pre_async", Out, V1_OUT);
        #2 Rst_n = 1'b0;
        #1 check("async_clear", Out, 128'h0);
        repeat (2) @(posedge Clk);
        #1 check("async_hold", Out, 128'h0);
        #1 Rst_n = 1'b1;
        In = V2_IN;
        @(posedge Clk);
        #1 check("post_release", Out, V2_OUT);

        // Random regression; the falling-edge process checks every cycle
        for (int i = 0; i < 1200; i++) begin
            #1 In = {$urandom, $urandom, $urandom, $urandom};
            @(posedge Clk);
        end
        @(negedge Clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
